truth_table_scanner: RTL

Sequencer that exercises a combinational N-input, 1-output boolean block (e.g. a 3-input sum-of-products or product-of-sums function) by driving every input vector in ascending order. It waits a programmable settle time, samples the output and assembles the full truth table. At the end it compares the table against an expected mask and reports pass/fail, the first mismatching vector and the count of true entries. It sits between a test/control host and the function under test, replacing hand-written stimulus sweeps.

---
 rtl/tt_scan_pkg.sv | 37 +++
 rtl/truth_table_scanner_settle_timer.sv | 32 +++
 rtl/truth_table_scanner.sv | 119 +++++++++++
 3 files changed

// File: rtl/tt_scan_pkg.sv
// Shared types and helpers for the truth-table scanner.
// State encoding plus popcount / lowest-set-bit helpers.
package tt_scan_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t WAIT   = 2'd1;
    localparam state_t SAMPLE = 2'd2;
    localparam state_t DONE   = 2'd3;

    // Number of set bits in a table of up to 64 entries
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

    // Lowest set bit position; 0 when no bit is set
    function automatic logic [5:0] first_set(input logic [63:0] v);
        logic [5:0] p;
        logic       f;
        p = '0;
        f = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (v[i] && !f) begin
                p = 6'(i);
                f = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle counter: counts WAIT cycles, flags the last one.
// Wraps back to zero on its own when the flag is taken.
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [W-1:0] LAST = W'(SETTLE - 1);

    logic [W-1:0] cnt;

    // Terminal flag on the final settle cycle
    always_comb tc = (cnt == LAST);

    // Counter: clear on request, step while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps every input vector of an N-input function, builds
// its truth table and checks it against a golden mask.
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int N      = 3,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2**N-1:0]   expected,
    input  logic              f_in,
    output logic [N-1:0]      vec,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   table_q,
    output logic              pass,
    output logic [N-1:0]      first_fail,
    output logic [N:0]        n_ones
);

    localparam int T = 2**N;

    state_t         state;
    state_t         state_nxt;
    logic [T-1:0]   exp_q;
    logic [T-1:0]   tbl_nxt;
    logic [N-1:0]   idx;
    logic           last;
    logic           tc;
    logic [N:0]     pc;
    logic [N-1:0]   ff;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .en    (state == WAIT),
        .tc    (tc)
    );

    // Table with the current sample merged in, and its results
    always_comb begin
        tbl_nxt      = table_q;
        tbl_nxt[idx] = f_in;
        last         = (idx == {N{1'b1}});
        pc           = (N+1)'(popcount(64'(tbl_nxt)));
        ff           = N'(first_set(64'(tbl_nxt ^ exp_q)));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (tc) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last ? DONE : WAIT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Index, vector, table and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q      <= '0;
            idx        <= '0;
            vec        <= '0;
            table_q    <= '0;
            pass       <= 1'b0;
            first_fail <= '0;
            n_ones     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        exp_q   <= expected;
                        idx     <= '0;
                        vec     <= '0;
                        table_q <= '0;
                        pass    <= 1'b0;
                    end
                end
                SAMPLE: begin
                    table_q <= tbl_nxt;
                    if (last) begin
                        pass       <= (tbl_nxt == exp_q);
                        first_fail <= ff;
                        n_ones     <= pc;
                    end else begin
                        idx <= idx + N'(1);
                        vec <= idx + N'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
